downsample_box: RTL and testbench
=================================

// Module: downsample_box
// PURPOSE
//  Parametrised box-filter downsampler, successor to the fixed 640x480->40x30 sampler.
//  - Averages every FACTOR_X x FACTOR_Y pixel tile of the incoming frame (horizontal and vertical).
//  - Stores each result in an on-chip frame buffer, read back by pixel address.
//  - Sits after the CSI-2 unpacker on the pixel clock, feeding low-res consumers (exposure, preview).
// PARAMETERS
//  IN_W      640  active input width in pixels; must be a multiple of FACTOR_X
//  IN_H      480  active input height in lines; must be a multiple of FACTOR_Y
//  PPC       4    pixels per pixel_data word
//  BPP       8    bits per pixel
//  FACTOR_X  16   horizontal decimation; power of 2, multiple of PPC
//  FACTOR_Y  16   vertical decimation; power of 2
//  Derived:
//   OUT_W = IN_W/FACTOR_X, OUT_H = IN_H/FACTOR_Y
//   XB = clog2(OUT_W), YB = clog2(OUT_H)
//   SH = log2(FACTOR_X*FACTOR_Y), ACC_W = BPP+SH
// PORTS
//  pixel_clock  in   1        sole clock
//  resetn       in   1        synchronous active-low reset
//  in_line      in   1        high during active line
//  in_frame     in   1        high during active frame
//  pixel_data   in   PPC*BPP  pixels, lowest byte = leftmost pixel
//  data_enable  in   1        pixel_data valid this cycle
//  read_x       in   XB       output column
//  read_y       in   YB       output row
//  read_q       out  BPP      tile average at {read_y,read_x}, 1-cycle latency
//  frame_done   out  1        1-cycle pulse when the last tile of a frame is written
// BEHAVIOUR
//  Clock and reset:
//  - One clock, pixel_clock. Reset is synchronous and active-low on resetn.
//  - On reset: read_q=0, frame_done=0; counters, accumulators and last_in_line cleared.
//  - Frame-buffer and line-accumulator RAM contents are not cleared by reset.
//  Frame and line control:
//  - in_frame low: x/y counters, horizontal sum and line phase cleared. No RAM writes.
//  - Line end is the falling edge of in_line while in_frame is high (last_in_line register). It does:
//    - y counter +1;
//    - x counter cleared;
//    - horizontal sum cleared.
//  - Beats count only when in_line && in_frame && data_enable; back-to-back beats are allowed.
//  - Beats with x >= IN_W, or lines with y >= IN_H, are ignored. Counters saturate at IN_W and IN_H.
//  Arithmetic:
//  - Each beat adds the PPC pixels to hsum, which is ACC_W wide and cannot overflow.
//  - A beat completes a group when it is the last of FACTOR_X/PPC beats.
//  - On group completion, with tx = x/FACTOR_X and ly = y%FACTOR_Y:
//    - ly==0: line_acc[tx] <= group sum.
//    - 0<ly<FACTOR_Y-1: line_acc[tx] += group sum.
//    - ly==FACTOR_Y-1: fb[{y/FACTOR_Y, tx}] <= (line_acc[tx]+group sum) >> SH. Truncated, no rounding.
//  - line_acc is a 1-read/1-write RAM of depth OUT_W, ACC_W wide. The frame-buffer write lands
//    exactly 2 cycles after the completing beat.
//  - Read-modify-write hazards cannot occur, because consecutive groups hit different tx.
//  - frame_done pulses in the same cycle as the fb write of tile (OUT_W-1, OUT_H-1).
//  Read port:
//  - read_q <= fb[{read_y,read_x}] every cycle.
//  - On a same-address write and read in one cycle, read_q returns the old data.
//  - Addresses with read_x>=OUT_W or read_y>=OUT_H return undefined data.
//  Boundaries:
//  - in_frame dropping mid-frame: no frame_done. Tiles already written are kept.
//  - resetn low mid-frame: same as in_frame dropping, plus read_q forced to 0 that cycle.
//  - A line shorter than IN_W leaves its partial group unaccumulated. The partial group is discarded at line end.
// CONFIGURATION
//  DOWNSAMPLE_BOX_DBUF_EN defined:
//  - fb is doubled into two banks, with bank select bit wbank (reset 0).
//  - Writes go to bank wbank; reads come from bank ~wbank.
//  - wbank toggles in the cycle after frame_done. Reads therefore always see the last complete frame.
//  - An aborted frame does not toggle wbank.
//  Undefined:
//  - Single bank. Reads see tiles as they are written, so the image tears.
// TESTING
//  Defaults, flat frame: all pixels 0x80 -> every read_q==0x80; exactly 1 frame_done.
//  Vertical average: in each 16-line group, lines 0-7 are 0xFF and lines 8-15 are 0x00
//    -> all tiles 0x7F (32640>>8).
//  Horizontal ramp: pixel value = x/16 -> tile (tx,ty) reads tx; frame_done 2 cycles after the final beat.
//  Gaps and abort: random data_enable gaps give identical results. Dropping in_frame at line 200
//    -> no frame_done; tiles for rows 0-11 kept.
//  Reset mid-frame: assert resetn=0 at line 100, then send a full 0x40 frame -> all tiles 0x40, read_q 0 during reset.
//  DBUF_EN: frame A=0x10, then frame B=0x90. Reads during B return 0x10; 1 cycle after B's frame_done, reads return 0x90.

Source files
------------

// File: rtl/downsample_box.sv
// Box-filter downsampler: averages FACTOR_X x FACTOR_Y tiles into an on-chip frame buffer.
// Optional double-buffered frame store is enabled by defining DOWNSAMPLE_BOX_DBUF_EN.
module downsample_box #(
    parameter int IN_W     = 640,
    parameter int IN_H     = 480,
    parameter int PPC      = 4,
    parameter int BPP      = 8,
    parameter int FACTOR_X = 16,
    parameter int FACTOR_Y = 16,
    localparam int OUT_W   = IN_W / FACTOR_X,
    localparam int OUT_H   = IN_H / FACTOR_Y,
    localparam int XB      = $clog2(OUT_W),
    localparam int YB      = $clog2(OUT_H)
) (
    input  logic               pixel_clock,
    input  logic               resetn,
    input  logic               in_line,
    input  logic               in_frame,
    input  logic [PPC*BPP-1:0] pixel_data,
    input  logic               data_enable,
    input  logic [XB-1:0]      read_x,
    input  logic [YB-1:0]      read_y,
    output logic [BPP-1:0]     read_q,
    output logic               frame_done
);

    localparam int SH    = $clog2(FACTOR_X * FACTOR_Y);
    localparam int ACC_W = BPP + SH;
    localparam int XW    = $clog2(IN_W + 1);
    localparam int YW    = $clog2(IN_H + 1);
    localparam int FXB   = $clog2(FACTOR_X);
    localparam int FYB   = $clog2(FACTOR_Y);
`ifdef DOWNSAMPLE_BOX_DBUF_EN
    localparam int FB_AW = YB + XB + 1;
`else
    localparam int FB_AW = YB + XB;
`endif
    localparam int FB_DEPTH = 1 << FB_AW;

    // ------------------------------------------------------------------
    // Input position tracking and horizontal accumulation
    // ------------------------------------------------------------------
    logic [XW-1:0]    x_cnt;
    logic [YW-1:0]    y_cnt;
    logic [ACC_W-1:0] hsum;
    logic             last_in_line;

    logic             beat;
    logic             line_end;
    logic             grp_last;
    logic             grp_done;
    logic [ACC_W-1:0] beat_sum;
    logic [ACC_W-1:0] grp_sum;
    logic [XB-1:0]    cur_tx;
    logic [YB-1:0]    cur_ty;
    logic [FYB-1:0]   cur_ly;

    always_comb begin
        beat_sum = '0;
        for (int p = 0; p < PPC; p++) begin
            beat_sum = beat_sum + ACC_W'(pixel_data[p*BPP +: BPP]);
        end
    end

    assign beat     = in_frame && in_line && data_enable
                      && (x_cnt < XW'(IN_W)) && (y_cnt < YW'(IN_H));
    assign line_end = in_frame && last_in_line && !in_line;
    assign grp_last = (x_cnt[FXB-1:0] == FXB'(FACTOR_X - PPC));
    assign grp_done = beat && grp_last;
    assign grp_sum  = hsum + beat_sum;
    assign cur_tx   = XB'(x_cnt >> FXB);
    assign cur_ty   = YB'(y_cnt >> FYB);
    assign cur_ly   = y_cnt[FYB-1:0];

    always_ff @(posedge pixel_clock) begin
        if (!resetn || !in_frame) begin
            x_cnt        <= '0;
            y_cnt        <= '0;
            hsum         <= '0;
            last_in_line <= 1'b0;
        end else begin
            last_in_line <= in_line;
            if (line_end) begin
                // A partial group left in hsum is discarded here.
                x_cnt <= '0;
                hsum  <= '0;
                if (y_cnt < YW'(IN_H)) begin
                    y_cnt <= y_cnt + YW'(1);
                end
            end else if (beat) begin
                x_cnt <= x_cnt + XW'(PPC);
                hsum  <= grp_last ? '0 : grp_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: completed group captured, line accumulator read issued
    // ------------------------------------------------------------------
    logic             s1_valid;
    logic [ACC_W-1:0] s1_sum;
    logic [XB-1:0]    s1_tx;
    logic [YB-1:0]    s1_ty;
    logic [FYB-1:0]   s1_ly;

    logic [ACC_W-1:0] line_acc [OUT_W];
    logic [ACC_W-1:0] line_acc_q;

    always_ff @(posedge pixel_clock) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= grp_done;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (grp_done) begin
            s1_sum     <= grp_sum;
            s1_tx      <= cur_tx;
            s1_ty      <= cur_ty;
            s1_ly      <= cur_ly;
            line_acc_q <= line_acc[cur_tx];
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: vertical accumulation; last line of a tile emits an average
    // ------------------------------------------------------------------
    logic [ACC_W-1:0] vsum;
    logic             s1_first;
    logic             s1_final;
    logic             s2_we;
    logic             s2_last;
    logic [YB+XB-1:0] s2_addr;
    logic [BPP-1:0]   s2_data;

    assign vsum     = line_acc_q + s1_sum;
    assign s1_first = (s1_ly == '0);
    assign s1_final = (s1_ly == FYB'(FACTOR_Y - 1));

    always_ff @(posedge pixel_clock) begin
        if (s1_valid && !s1_final) begin
            line_acc[s1_tx] <= s1_first ? s1_sum : vsum;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (!resetn) begin
            s2_we   <= 1'b0;
            s2_last <= 1'b0;
        end else begin
            s2_we   <= s1_valid && s1_final;
            s2_last <= s1_valid && s1_final
                       && (s1_tx == XB'(OUT_W - 1)) && (s1_ty == YB'(OUT_H - 1));
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (s1_valid && s1_final) begin
            s2_addr <= {s1_ty, s1_tx};
            s2_data <= vsum[ACC_W-1:SH];
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer and read port
    // ------------------------------------------------------------------
    logic [BPP-1:0]   fb [FB_DEPTH];
    logic [FB_AW-1:0] fb_waddr;
    logic [FB_AW-1:0] fb_raddr;

`ifdef DOWNSAMPLE_BOX_DBUF_EN
    logic wbank;
    logic rbank;

    // During the frame_done cycle the just-completed bank is already readable.
    assign rbank    = frame_done ? wbank : ~wbank;
    assign fb_waddr = {wbank, s2_addr};
    assign fb_raddr = {rbank, read_y, read_x};

    always_ff @(posedge pixel_clock) begin
        if (!resetn) begin
            wbank <= 1'b0;
        end else if (frame_done) begin
            wbank <= ~wbank;
        end
    end
`else
    assign fb_waddr = s2_addr;
    assign fb_raddr = {read_y, read_x};
`endif

    always_ff @(posedge pixel_clock) begin
        if (s2_we) begin
            fb[fb_waddr] <= s2_data;
        end
    end

    always_ff @(posedge pixel_clock) begin
        if (!resetn) begin
            read_q     <= '0;
            frame_done <= 1'b0;
        end else begin
            read_q     <= fb[fb_raddr];
            frame_done <= s2_we && s2_last;
        end
    end

endmodule

// File: tb/tb_downsample_box.sv
// Directed bench for downsample_box on a reduced 64x48 frame (4x3 tiles of 16x16).
// Define DOWNSAMPLE_BOX_DBUF_EN to build the double-buffered variant and its checks.
module tb_downsample_box;

    localparam int W  = 64;
    localparam int H  = 48;
    localparam int OW = 4;
    localparam int OH = 3;

    logic        clk;
    logic        resetn;
    logic        in_line;
    logic        in_frame;
    logic [31:0] pixel_data;
    logic        data_enable;
    logic [1:0]  read_x;
    logic [1:0]  read_y;
    logic [7:0]  read_q;
    logic        frame_done;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          fd_count = 0;
    int          fd_cyc   = 0;
    int          last_beat_cyc = 0;
    logic        fd_prev  = 1'b0;
    logic [7:0]  q_after_fd = 8'h00;
    logic [7:0]  mid_q    = 8'h00;
    logic [7:0]  exp_q[$];

    downsample_box #(
        .IN_W(W),
        .IN_H(H)
    ) dut (
        .pixel_clock(clk),
        .resetn(resetn),
        .in_line(in_line),
        .in_frame(in_frame),
        .pixel_data(pixel_data),
        .data_enable(data_enable),
        .read_x(read_x),
        .read_y(read_y),
        .read_q(read_q),
        .frame_done(frame_done)
    );

    // ---------------- clock / reset / monitors ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        fd_prev <= (frame_done === 1'b1);
        if (fd_prev) q_after_fd <= read_q;
        if (frame_done === 1'b1) begin
            fd_count <= fd_count + 1;
            fd_cyc   <= cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / checks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 flat, 1 vertical halves, 2 horizontal ramp, 3 diagonal pattern
    function automatic logic [7:0] pix(input int mode, input logic [7:0] val, input int x, input int y);
        case (mode)
            0:       return val;
            1:       return ((y % 16) < 8) ? 8'hFF : 8'h00;
            2:       return 8'(x / 16);
            default: return 8'((x * 7 + y * 13) & 255);
        endcase
    endfunction

    function automatic logic [7:0] tile_avg(input int mode, input logic [7:0] val, input int tx, input int ty);
        int sum;
        sum = 0;
        for (int yy = 0; yy < 16; yy++)
            for (int xx = 0; xx < 16; xx++)
                sum += int'(pix(mode, val, tx * 16 + xx, ty * 16 + yy));
        return 8'(sum >> 8);
    endfunction

    task automatic push_frame(input int mode, input logic [7:0] val);
        for (int ty = 0; ty < OH; ty++)
            for (int tx = 0; tx < OW; tx++)
                exp_q.push_back(tile_avg(mode, val, tx, ty));
    endtask

    task automatic check_tiles(input string tag);
        logic [7:0] e;
        for (int ty = 0; ty < OH; ty++) begin
            for (int tx = 0; tx < OW; tx++) begin
                @(negedge clk);
                read_x = 2'(tx);
                read_y = 2'(ty);
                @(negedge clk);
                e = exp_q.pop_front();
                check($sformatf("%s_tile_%0d_%0d", tag, tx, ty), read_q, e);
            end
        end
    endtask

    // ---------------- driver ----------------
    // abort_kind: 0 none, 1 drop in_frame at abort_line, 2 reset mid-line at abort_line
    task automatic send_frame(input int mode, input logic [7:0] val, input bit gaps,
                              input int abort_kind, input int abort_line, input int mid_line);
        int b;
        @(negedge clk);
        in_frame = 1'b1;
        in_line = 1'b0;
        data_enable = 1'b0;
        repeat (2) @(negedge clk);
        for (int y = 0; y < H; y++) begin
            if (y == mid_line) mid_q = read_q;
            if (abort_kind == 1 && y == abort_line) begin
                in_frame = 1'b0;
                repeat (3) @(negedge clk);
                return;
            end
            in_line = 1'b1;
            b = 0;
            while (b < W / 4) begin
                if (abort_kind == 2 && y == abort_line && b == 5) begin
                    resetn = 1'b0;
                    data_enable = 1'b1;
                    @(negedge clk);
                    check("reset_mid_read_q", read_q, 8'h00);
                    check("reset_mid_frame_done", frame_done, 1'b0);
                    @(negedge clk);
                    resetn = 1'b1;
                    in_frame = 1'b0;
                    in_line = 1'b0;
                    data_enable = 1'b0;
                    repeat (3) @(negedge clk);
                    return;
                end
                if (gaps && $urandom_range(0, 2) == 0) begin
                    data_enable = 1'b0;
                    pixel_data = $urandom;
                end else begin
                    data_enable = 1'b1;
                    for (int p = 0; p < 4; p++)
                        pixel_data[p*8 +: 8] = pix(mode, val, b * 4 + p, y);
                    last_beat_cyc = cyc + 1;
                    b++;
                end
                @(negedge clk);
            end
            in_line = 1'b0;
            data_enable = 1'b0;
            repeat (3) @(negedge clk);
        end
        in_frame = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        resetn = 1'b0;
        in_line = 1'b0;
        in_frame = 1'b0;
        data_enable = 1'b0;
        pixel_data = '0;
        read_x = '0;
        read_y = '0;
        repeat (3) @(negedge clk);
        check("reset_read_q", read_q, 8'h00);
        check("reset_frame_done", frame_done, 1'b0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // flat 0x80 -> every tile 0x80, one frame_done
        send_frame(0, 8'h80, 1'b0, 0, -1, -1);
        check("flat_done_count", fd_count, 1);
        push_frame(0, 8'h80);
        check_tiles("flat");

        // vertical halves -> 32640 >> 8 = 0x7F everywhere
        send_frame(1, 8'h00, 1'b0, 0, -1, -1);
        check("vert_done_count", fd_count, 2);
        for (int i = 0; i < OW * OH; i++) exp_q.push_back(8'h7F);
        check_tiles("vert");

        // horizontal ramp -> tile reads tx; frame_done 2 cycles after the final beat
        send_frame(2, 8'h00, 1'b0, 0, -1, -1);
        check("ramp_done_count", fd_count, 3);
        check("ramp_done_latency", fd_cyc - last_beat_cyc, 2);
        for (int ty = 0; ty < OH; ty++)
            for (int tx = 0; tx < OW; tx++)
                exp_q.push_back(8'(tx));
        check_tiles("ramp");

        // diagonal pattern with random data_enable gaps
        send_frame(3, 8'h00, 1'b1, 0, -1, -1);
        check("gaps_done_count", fd_count, 4);
        push_frame(3, 8'h00);
        check_tiles("gaps");

        // flat 0x20, then a 0x60 frame aborted at line 40
        send_frame(0, 8'h20, 1'b0, 0, -1, -1);
        check("pre_abort_done_count", fd_count, 5);
        send_frame(0, 8'h60, 1'b0, 1, 40, -1);
        check("abort_done_count", fd_count, 5);
`ifdef DOWNSAMPLE_BOX_DBUF_EN
        push_frame(0, 8'h20);
`else
        for (int i = 0; i < OW * 2; i++) exp_q.push_back(8'h60);
        for (int i = 0; i < OW; i++) exp_q.push_back(8'h20);
`endif
        check_tiles("abort");

        // reset asserted mid-frame at line 20, then a full 0x40 frame
        @(negedge clk);
        read_x = 2'd0;
        read_y = 2'd0;
        send_frame(0, 8'h30, 1'b0, 2, 20, -1);
        check("reset_abort_done_count", fd_count, 5);
        @(negedge clk);
        read_x = 2'd3;
        read_y = 2'd2;
        send_frame(0, 8'h40, 1'b0, 0, -1, -1);
        check("post_reset_done_count", fd_count, 6);
        check("after_done_last_tile", q_after_fd, 8'h40);
        push_frame(0, 8'h40);
        check_tiles("post_reset");

`ifdef DOWNSAMPLE_BOX_DBUF_EN
        // frame A = 0x10 then B = 0x90; reads during B see A
        @(negedge clk);
        read_x = 2'd0;
        read_y = 2'd0;
        send_frame(0, 8'h10, 1'b0, 0, -1, -1);
        send_frame(0, 8'h90, 1'b0, 0, -1, 40);
        check("dbuf_during_b", mid_q, 8'h10);
        check("dbuf_after_b_done", q_after_fd, 8'h90);
        check("dbuf_done_count", fd_count, 8);
        push_frame(0, 8'h90);
        check_tiles("dbuf_b");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
